// File: rtl/bitop_pkg.sv
// Shared types and constants for the bitop_arbiter block: opcode and FSM state
// encodings, plus the width of the optional grant counters.
package bitop_pkg;

    // Requester opcode encoding as seen on op0_i / op1_i.
    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    // One accepted operation walks IDLE -> EXEC -> RESP -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Width of the optional per-requester grant counters.
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/bitop_arbiter_if.sv
// Request/response bundle of bitop_arbiter: two requesters, each with an
// opcode and two operands, a combinational grant strobe and a registered
// valid/ready response channel.
interface bitop_arbiter_if #(
    parameter int N = 8
);
    logic [1:0]   req_i;
    logic [1:0]   op0_i;
    logic [N-1:0] a0_i;
    logic [N-1:0] b0_i;
    logic [1:0]   op1_i;
    logic [N-1:0] a1_i;
    logic [N-1:0] b1_i;
    logic [1:0]   gnt_o;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic         rsp_id_o;
    logic [N-1:0] rsp_data_o;

    // Requesters and response consumer side.
    modport master (
        output req_i, op0_i, a0_i, b0_i, op1_i, a1_i, b1_i, rsp_ready_i,
        input  gnt_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, op0_i, a0_i, b0_i, op1_i, a1_i, b1_i, rsp_ready_i,
        output gnt_o, rsp_valid_o, rsp_id_o, rsp_data_o
    );
endinterface

// File: rtl/bitop_arbiter_unit.sv
// bitop_unit: purely combinational bitwise operator shared by both requesters.
// The result is exactly N bits; there is no carry or sign extension.
module bitop_unit
    import bitop_pkg::*;
#(
    parameter int N = 8
) (
    input  op_e          op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    // Select the bitwise function named by the opcode.
    always_comb begin
        // NOTE: give every always_comb output a value before any branch so no path can infer a latch.
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/bitop_arbiter.sv
// bitop_arbiter: round-robin arbiter between two requesters feeding one shared
// bitwise unit. A grant in IDLE captures the winner's opcode, operands and id,
// EXEC registers the result, and RESP presents it until the consumer accepts.
// Optional feature: define BITOP_ARBITER_STATS_EN to add the saturating
// per-requester grant counters gnt_cnt0_o / gnt_cnt1_o.
module bitop_arbiter
    import bitop_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bitop_arbiter_if.slave   bus
`ifdef BITOP_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt0_o,
    output logic [CNT_W-1:0] gnt_cnt1_o
`endif
);

    state_e       state_q, state_d;
    logic         prio_q, prio_d;   // requester that wins a simultaneous request
    logic         win;              // requester chosen this cycle
    logic [1:0]   gnt;              // grant before reset gating
    logic         take;             // a grant is issued this cycle
    op_e          op_sel;
    logic [N-1:0] a_sel, b_sel;

    op_e          op_q;
    logic [N-1:0] a_q, b_q;
    logic         id_q;
    logic [N-1:0] data_q;
    logic [N-1:0] y;

    // Next-state, arbitration and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        win     = 1'b0;
        gnt     = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i != 2'b00) begin
                    // A lone requester wins outright; a tie goes to the favoured one.
                    win     = (bus.req_i == 2'b11) ? prio_q : bus.req_i[1];
                    gnt     = win ? 2'b10 : 2'b01;
                    prio_d  = ~win;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Route the winner's opcode and operands toward the capture registers.
    always_comb begin
        op_sel = win ? op_e'(bus.op1_i) : op_e'(bus.op0_i);
        a_sel  = win ? bus.a1_i : bus.a0_i;
        b_sel  = win ? bus.b1_i : bus.b0_i;
    end

    assign take = (gnt != 2'b00);

    // State register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= ST_IDLE;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Capture the winning transaction on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= OP_AND;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (take) begin
            op_q <= op_sel;
            a_q  <= a_sel;
            b_q  <= b_sel;
            id_q <= win;
        end
    end

    bitop_unit #(.N(N)) u_unit (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .y  (y)
    );

    // Register the result at the end of EXEC; it then stays put through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (state_q == ST_EXEC) begin
            data_q <= y;
        end
    end

    // While reset is held the FSM sits in IDLE, so the strobe is masked explicitly.
    assign bus.gnt_o       = rst_n ? gnt : 2'b00;
    assign bus.rsp_valid_o = (state_q == ST_RESP);
    assign bus.rsp_id_o    = id_q;
    assign bus.rsp_data_o  = data_q;

`ifdef BITOP_ARBITER_STATS_EN
    logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt1_q;

    // Saturating grant counters, one per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            if (gnt[0] && (gnt_cnt0_q != '1)) begin
                gnt_cnt0_q <= gnt_cnt0_q + 1'b1;
            end
            if (gnt[1] && (gnt_cnt1_q != '1)) begin
                gnt_cnt1_q <= gnt_cnt1_q + 1'b1;
            end
        end
    end

    assign gnt_cnt0_o = gnt_cnt0_q;
    assign gnt_cnt1_o = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_bitop_arbiter.sv
// Self-checking bench for bitop_arbiter: a vector table of single-requester
// operations, hand sequences for round-robin streaming, response back-pressure
// and reset during EXEC, then randomized traffic against a transaction-level
// model. Counter checks are compiled when BITOP_ARBITER_STATS_EN is defined.
module tb_bitop_arbiter;
    import bitop_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bitop_arbiter_if #(.N(N)) bus ();

`ifdef BITOP_ARBITER_STATS_EN
    logic [15:0] gnt_cnt0_o, gnt_cnt1_o;
`endif

    bitop_arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BITOP_ARBITER_STATS_EN
        ,
        .gnt_cnt0_o (gnt_cnt0_o),
        .gnt_cnt1_o (gnt_cnt1_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model state: who wins a tie, and grants per requester.
    logic m_prio;
    int   m_cnt0, m_cnt1;

    typedef struct {
        string        name;
        logic [1:0]   req;
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         exp_id;
        logic [N-1:0] exp_y;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bitwise reference via per-opcode truth tables indexed by {a_bit, b_bit}.
    function automatic logic [N-1:0] ref_op(input logic [1:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [3:0]   tt;
        logic [N-1:0] r;
        case (op)
            2'd0:    tt = 4'b1000;
            2'd1:    tt = 4'b1110;
            2'd2:    tt = 4'b0110;
            default: tt = 4'b0001;
        endcase
        for (int i = 0; i < N; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic [N-1:0] rnd_n();
        logic [31:0] r;
        r = $urandom;
        return r[N-1:0];
    endfunction

    function automatic logic [1:0] rnd2();
        logic [31:0] r;
        r = $urandom;
        return r[1:0];
    endfunction

    task automatic scramble();
        bus.op0_i = rnd2();
        bus.a0_i  = rnd_n();
        bus.b0_i  = rnd_n();
        bus.op1_i = rnd2();
        bus.a1_i  = rnd_n();
        bus.b1_i  = rnd_n();
    endtask

    task automatic model_grant(input logic id);
        m_prio = ~id;
        if (id) begin
            if (m_cnt1 < 65535) m_cnt1++;
        end else begin
            if (m_cnt0 < 65535) m_cnt0++;
        end
    endtask

    // Full reset: checks outputs while held, releases on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_data",  32'(bus.rsp_data_o),  32'd0);
        check("rst_id",    32'(bus.rsp_id_o),    32'd0);
        check("rst_gnt",   32'(bus.gnt_o),       32'd0);
`ifdef BITOP_ARBITER_STATS_EN
        check("rst_cnt0", 32'(gnt_cnt0_o), 32'd0);
        check("rst_cnt1", 32'(gnt_cnt1_o), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        m_prio = 1'b0;
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    // One complete operation. Starts and ends on a falling edge with the FSM in IDLE.
    task automatic do_txn(input string tag, input logic [1:0] req,
                          input logic [1:0] op0, input logic [N-1:0] a0, input logic [N-1:0] b0,
                          input logic [1:0] op1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                          input int hold, input logic exp_id, input logic [N-1:0] exp_y);
        logic [31:0] r;
        bus.req_i = req;
        bus.op0_i = op0; bus.a0_i = a0; bus.b0_i = b0;
        bus.op1_i = op1; bus.a1_i = a1; bus.b1_i = b1;
        r = $urandom;
        bus.rsp_ready_i = r[0];           // ignored outside RESP
        #1;
        check({tag, "_gnt"}, 32'(bus.gnt_o), exp_id ? 32'd2 : 32'd1);
        check({tag, "_idle_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        model_grant(exp_id);

        @(negedge clk);                   // EXEC
        check({tag, "_exec_gnt"},   32'(bus.gnt_o),       32'd0);
        check({tag, "_exec_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        scramble();
        r = $urandom;
        bus.rsp_ready_i = r[0];

        @(negedge clk);                   // first RESP cycle
        check({tag, "_valid"}, 32'(bus.rsp_valid_o), 32'd1);
        check({tag, "_data"},  32'(bus.rsp_data_o),  32'(exp_y));
        check({tag, "_id"},    32'(bus.rsp_id_o),    32'(exp_id));
        check({tag, "_resp_gnt"}, 32'(bus.gnt_o), 32'd0);
        for (int k = 0; k < hold; k++) begin
            bus.rsp_ready_i = 1'b0;
            scramble();
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid_o), 32'd1);
            check({tag, "_hold_data"},  32'(bus.rsp_data_o),  32'(exp_y));
            check({tag, "_hold_id"},    32'(bus.rsp_id_o),    32'(exp_id));
            check({tag, "_hold_gnt"},   32'(bus.gnt_o),       32'd0);
        end
        bus.req_i       = 2'b00;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);                   // back in IDLE
        check({tag, "_done_valid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_done_gnt"},   32'(bus.gnt_o),       32'd0);
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        logic [1:0]   rq, o0, o1;
        logic [N-1:0] x0, y0, x1, y1, ey;
        logic         eid;
        logic [31:0]  r;
        int           h;

        rst_n = 1'b0;
        bus.req_i = 2'b00;
        bus.op0_i = 2'b00; bus.a0_i = '0; bus.b0_i = '0;
        bus.op1_i = 2'b00; bus.a1_i = '0; bus.b1_i = '0;
        bus.rsp_ready_i = 1'b0;
        m_prio = 1'b0; m_cnt0 = 0; m_cnt1 = 0;

        vecs[0] = '{"or_r0",   2'b01, 2'd1, 8'b10010110, 8'b10101010, 1'b0, 8'hBE};
        vecs[1] = '{"and_r0",  2'b01, 2'd0, 8'b10010110, 8'b10101010, 1'b0, 8'h82};
        vecs[2] = '{"xor_r0",  2'b01, 2'd2, 8'b10010110, 8'b10101010, 1'b0, 8'h3C};
        vecs[3] = '{"nor_r0",  2'b01, 2'd3, 8'b10010110, 8'b10101010, 1'b0, 8'h41};
        vecs[4] = '{"nor_zero",2'b10, 2'd3, 8'h00,       8'h00,       1'b1, 8'hFF};
        vecs[5] = '{"and_ones",2'b10, 2'd0, 8'hFF,       8'hFF,       1'b1, 8'hFF};
        vecs[6] = '{"xor_same",2'b01, 2'd2, 8'hFF,       8'hFF,       1'b0, 8'h00};
        vecs[7] = '{"or_alt",  2'b10, 2'd1, 8'hA5,       8'h5A,       1'b1, 8'hFF};

        do_reset();

        // Vector table: a single requester each time; the other port carries decoys.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].req == 2'b01)
                do_txn(vecs[i].name, vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b,
                       ~vecs[i].op, ~vecs[i].a, vecs[i].b, 0, vecs[i].exp_id, vecs[i].exp_y);
            else
                do_txn(vecs[i].name, vecs[i].req, ~vecs[i].op, ~vecs[i].a, vecs[i].b,
                       vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].exp_id, vecs[i].exp_y);
        end

        // Back-pressure: five stalled RESP cycles while inputs move.
        do_txn("stall", 2'b01, 2'd1, 8'b10010110, 8'b10101010, 2'd0, 8'h00, 8'h00,
               5, 1'b0, 8'hBE);

        // Both requesters held with ready high: grants alternate every third cycle.
        do_reset();
        bus.req_i = 2'b11;
        bus.rsp_ready_i = 1'b1;
        bus.op0_i = 2'd2; bus.a0_i = 8'hF0; bus.b0_i = 8'h3C;
        bus.op1_i = 2'd0; bus.a1_i = 8'hF0; bus.b1_i = 8'h3C;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (c % 3 == 0) begin
                check("rr_gnt", 32'(bus.gnt_o), ((c / 3) % 2 == 1) ? 32'd2 : 32'd1);
                model_grant(((c / 3) % 2) == 1);
            end else begin
                check("rr_gap_gnt", 32'(bus.gnt_o), 32'd0);
            end
            if (c % 3 == 2) begin
                check("rr_valid", 32'(bus.rsp_valid_o), 32'd1);
                check("rr_id",    32'(bus.rsp_id_o),    32'((c / 3) % 2));
                check("rr_data",  32'(bus.rsp_data_o),
                      ((c / 3) % 2 == 1) ? 32'(ref_op(2'd0, 8'hF0, 8'h3C))
                                         : 32'(ref_op(2'd2, 8'hF0, 8'h3C)));
            end
            @(negedge clk);
        end
        bus.req_i = 2'b00;
        bus.rsp_ready_i = 1'b0;

        // Reset while in EXEC: no response, outputs cleared, pointer back to requester 0.
        bus.req_i = 2'b10;
        #1;
        check("rx_gnt", 32'(bus.gnt_o), 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rx_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rx_data",  32'(bus.rsp_data_o),  32'd0);
        check("rx_id",    32'(bus.rsp_id_o),    32'd0);
        check("rx_gnt0",  32'(bus.gnt_o),       32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rx_hold_valid", 32'(bus.rsp_valid_o), 32'd0);
        end
        rst_n  = 1'b1;
        m_prio = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
        do_txn("rx_after", 2'b11, 2'd1, 8'h0F, 8'h30, 2'd2, 8'hFF, 8'h00,
               1, 1'b0, 8'h3F);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            rq = rnd2();
            if (rq == 2'b00) begin
                bus.req_i = 2'b00;
                r = $urandom;
                bus.rsp_ready_i = r[0];
                #1;
                check("rnd_idle_gnt",   32'(bus.gnt_o),       32'd0);
                check("rnd_idle_valid", 32'(bus.rsp_valid_o), 32'd0);
                @(negedge clk);
            end else begin
                o0 = rnd2(); x0 = rnd_n(); y0 = rnd_n();
                o1 = rnd2(); x1 = rnd_n(); y1 = rnd_n();
                eid = (rq == 2'b11) ? m_prio : rq[1];
                ey  = eid ? ref_op(o1, x1, y1) : ref_op(o0, x0, y0);
                h   = $urandom_range(3, 0);
                do_txn("rnd", rq, o0, x0, y0, o1, x1, y1, h, eid, ey);
            end
        end

`ifdef BITOP_ARBITER_STATS_EN
        check("cnt0_model", 32'(gnt_cnt0_o), 32'(m_cnt0));
        check("cnt1_model", 32'(gnt_cnt1_o), 32'(m_cnt1));

        do_reset();
        for (int i = 0; i < 3; i++)
            do_txn("st0", 2'b01, 2'd0, 8'hFF, 8'h0F, 2'd0, 8'h00, 8'h00, 0, 1'b0, 8'h0F);
        for (int i = 0; i < 2; i++)
            do_txn("st1", 2'b10, 2'd0, 8'h00, 8'h00, 2'd1, 8'hF0, 8'h0F, 0, 1'b1, 8'hFF);
        check("cnt0_three", 32'(gnt_cnt0_o), 32'd3);
        check("cnt1_two",   32'(gnt_cnt1_o), 32'd2);

        // Preset both counters just below the ceiling, then push past it.
        force dut.gnt_cnt0_q = 16'hFFFE;
        force dut.gnt_cnt1_q = 16'hFFFD;
        #1;
        release dut.gnt_cnt0_q;
        release dut.gnt_cnt1_q;
        for (int i = 0; i < 3; i++) begin
            do_txn("sat", 2'b11, 2'd1, 8'h01, 8'h02, 2'd1, 8'h04, 8'h08, 0,
                   m_prio, m_prio ? 8'h0C : 8'h03);
        end
        for (int i = 0; i < 3; i++)
            do_txn("sat1", 2'b10, 2'd3, 8'h00, 8'h00, 2'd3, 8'h00, 8'h00, 0, 1'b1, 8'hFF);
        check("cnt0_sat", 32'(gnt_cnt0_o), 32'h0000FFFF);
        check("cnt1_sat", 32'(gnt_cnt1_o), 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitop_arbiter.md
BITOP_ARBITER -- requirements
Module: bitop_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_i, input, 2 bits: request from requester 0 (bit 0) and requester 1 (bit 1), level-held until granted.
REQ-005 SHALL have port op0_i, input, 2 bits: requester 0 opcode; 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-006 SHALL have ports a0_i and b0_i, input, N bits each: requester 0 operands.
REQ-007 SHALL have ports op1_i (2 bits), a1_i (N bits) and b1_i (N bits), input: requester 1 opcode and operands.
REQ-008 SHALL have port gnt_o, input-to-output combinational, output, 2 bits, one-hot or zero: accept strobe for the winning requester.
REQ-009 SHALL have port rsp_valid_o, output, 1 bit: result valid.
REQ-010 SHALL have port rsp_ready_i, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port rsp_id_o, output, 1 bit: index of the requester that owns the result.
REQ-012 SHALL have port rsp_data_o, output, N bits: registered result.

Function
REQ-013 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-014 In IDLE with any req_i bit set, SHALL assert exactly one gnt_o bit in the same cycle.
REQ-015 On the edge ending that cycle, SHALL latch the winner's opcode, operands and id, and go to EXEC.
REQ-016 gnt_o SHALL be 0 in EXEC and RESP.
REQ-017 In IDLE with no request, SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: on a simultaneous request, the requester not granted last wins; with a single request, that requester wins regardless of the pointer.
REQ-019 The round-robin pointer SHALL update only on a grant.
REQ-020 EXEC SHALL last exactly one cycle; its ending edge registers op(a,b) into rsp_data_o and enters RESP.
REQ-021 rsp_valid_o SHALL be 1 exactly while in RESP, so the first valid cycle follows the grant cycle by 2 cycles.
REQ-022 In RESP, rsp_data_o and rsp_id_o SHALL be held stable; input changes SHALL have no effect.
REQ-023 In RESP with rsp_ready_i=1, SHALL return to IDLE on the next edge; the earliest next grant is the following cycle, giving 1 operation per 3 cycles at best.
REQ-024 The result SHALL be bitwise and exactly N bits wide, with no carry or extension.
REQ-025 rsp_ready_i outside RESP SHALL be ignored.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, RR pointer favours requester 0, gnt_o=0.
REQ-027 Reset mid-operation (EXEC or RESP) SHALL abandon the transaction with no response produced, and rsp_valid_o SHALL fall immediately.
REQ-028 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Configuration
REQ-029 Macro BITOP_ARBITER_STATS_EN, when defined, SHALL add outputs gnt_cnt0_o and gnt_cnt1_o, 16 bits each.
REQ-030 With the macro defined, each counter SHALL count grants to its requester, saturate at 16'hFFFF, and reset to 0.
REQ-031 Without the macro, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package bitop_pkg SHALL hold the opcode enum (OP_AND, OP_OR, OP_XOR, OP_NOR), the FSM state enum, and the counter width constant 16.
REQ-033 The shared datapath SHALL be a separate combinational sub-module, bitop_unit #(N) (op, a, b -> y), instantiated once.

Verification
REQ-034 Bench SHALL check: reset release, req_i=01, op0=OR, a0=8'b10010110, b0=8'b10101010 -> gnt_o=01 same cycle; rsp_valid_o 2 cycles later with rsp_data_o=8'hBE, rsp_id_o=0.
REQ-035 Bench SHALL check: same operands with AND/XOR/NOR -> 8'h82 / 8'h3C / 8'h41.
REQ-036 Bench SHALL check: req_i=11 held continuously after reset, rsp_ready_i=1 -> grants alternate 0,1,0,1 with one grant every 3 cycles.
REQ-037 Bench SHALL check: rsp_ready_i=0 for 5 cycles in RESP while a0_i and op0_i change -> rsp_valid_o held, data unchanged, gnt_o=0; ready=1 -> IDLE next cycle.
REQ-038 Bench SHALL check: rst_n pulled low during EXEC -> rsp_valid_o never rises and outputs are 0; a request after release is granted to requester 0 when req_i=11.
REQ-039 Bench SHALL check (BITOP_ARBITER_STATS_EN): 3 grants to 0 and 2 to 1 -> gnt_cnt0_o=3, gnt_cnt1_o=2; with counters preset near the maximum, they saturate at 16'hFFFF.
